// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the N-channel sequencing multiplexer.
package mux_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Upper bounds for chan_slice; DATA_W*N_CH of any user must fit in MAX_BUS_W.
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_BUS_W  = 4096;

    function automatic logic [MAX_DATA_W-1:0] chan_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          dw,
        input int unsigned          k
    );
        logic [MAX_BUS_W-1:0]  shifted;
        logic [MAX_DATA_W-1:0] mask;
        shifted = bus >> (k * dw);
        mask    = ~({MAX_DATA_W{1'b1}} << dw);
        return shifted[MAX_DATA_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 channel selector; generalisation of the 2:1 mux.
module mux_n_1
    import mux_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic [N_CH*DATA_W-1:0] bus_i,
    input  logic [SEL_W-1:0]       sel_i,
    output logic [DATA_W-1:0]      data_o
);

    logic [MAX_BUS_W-1:0]  bus_ext_s;
    logic [MAX_DATA_W-1:0] slice_s;

    // Zero-extend the bus to the helper width and pick channel sel_i.
    always_comb begin
        bus_ext_s                  = '0;
        bus_ext_s[N_CH*DATA_W-1:0] = bus_i;
        slice_s                    = chan_slice(bus_ext_s, 32'(DATA_W), 32'(sel_i));
        data_o                     = slice_s[DATA_W-1:0];
    end

endmodule

// File: rtl/mux_seq_n.sv
// Snapshots N channels on start and streams them (SCAN) or one of them (DIRECT)
// over a valid/ready interface with fully registered outputs.
module mux_seq_n
    import mux_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   start,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel_in,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err
);

    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

    state_t                 state_q, state_d;
    logic [N_CH*DATA_W-1:0] snap_q, snap_d;
    logic [SEL_W-1:0]       idx_q, idx_d;
    logic [SEL_W-1:0]       last_idx_q, last_idx_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [SEL_W-1:0]       out_ch_q, out_ch_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      mux_data_s;

    // Outputs are registered from next-state values, so the mux looks ahead.
    mux_n_1 #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .SEL_W  (SEL_W)
    ) u_mux (
        .bus_i  (snap_d),
        .sel_i  (idx_d),
        .data_o (mux_data_s)
    );

    // Next-state logic: start decode, beat advance and output preparation.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !mode) begin
                    snap_d     = in_data;
                    idx_d      = '0;
                    last_idx_d = LAST_CH;
                    state_d    = EMIT;
                end else if (start && ({1'b0, sel_in} < N_CH_EXT)) begin
                    snap_d     = in_data;
                    idx_d      = sel_in;
                    last_idx_d = sel_in;
                    state_d    = EMIT;
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = IDLE;
                end else if (out_valid_q && out_ready) begin
                    idx_d = idx_q + SEL_W'(1);
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == EMIT) begin
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            out_data_d  = mux_data_s;
            out_ch_d    = idx_d;
            out_last_d  = (idx_d == last_idx_d);
        end else begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            out_data_d  = '0;
            out_ch_d    = '0;
            out_last_d  = 1'b0;
        end
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mux_seq_n.sv
// Directed bench for mux_seq_n: scoreboarded beats for N_CH=4, err path on N_CH=3.
module tb_mux_seq_n;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
        logic       last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        start, mode, out_ready;
    logic [1:0]  sel_in;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid, out_last, busy, err;

    logic [23:0] in3_data;
    logic        start3, mode3, ready3;
    logic [1:0]  sel3;
    logic [7:0]  out3_data;
    logic [1:0]  out3_ch;
    logic        out3_valid, out3_last, busy3, err3;

    int    errors = 0;
    int    checks = 0;
    beat_t sb[$];

    mux_seq_n #(.DATA_W(8), .N_CH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .start(start), .mode(mode),
        .sel_in(sel_in), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .err(err)
    );

    mux_seq_n #(.DATA_W(8), .N_CH(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in3_data), .start(start3), .mode(mode3),
        .sel_in(sel3), .out_data(out3_data), .out_ch(out3_ch), .out_valid(out3_valid),
        .out_ready(ready3), .out_last(out3_last), .busy(busy3), .err(err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_scan(input logic [31:0] bus);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.d    = bus[k*8 +: 8];
            b.ch   = 2'(k);
            b.last = (k == 3);
            sb.push_back(b);
        end
    endtask

    // One clock: score any handshake at the coming edge, then settle past it.
    task automatic step();
        beat_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("beat_data", 32'(out_data), 32'(e.d));
                chk("beat_ch",   32'(out_ch),   32'(e.ch));
                chk("beat_last", 32'(out_last), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (busy || sb.size() != 0); i++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_idle",  32'(busy),      32'd0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        in_data = 32'd0; start = 1'b0; mode = 1'b0; sel_in = 2'd0; out_ready = 1'b1;
        in3_data = 24'd0; start3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; ready3 = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ch",    32'(out_ch),    32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_err",   32'(err),       32'd0);

        // SCAN with ready held high
        in_data = 32'h4433_2211; start = 1'b1; mode = 1'b0;
        push_scan(32'h4433_2211);
        step();
        start = 1'b0;
        chk("scan_lat_valid", 32'(out_valid), 32'd1);
        chk("scan_lat_busy",  32'(busy),      32'd1);
        repeat (4) step();
        chk("scan_done_busy",  32'(busy),      32'd0);
        chk("scan_done_valid", 32'(out_valid), 32'd0);
        chk("scan_done_sb",    32'(sb.size()), 32'd0);

        // Backpressure on beat ch1
        start = 1'b1; push_scan(32'h4433_2211);
        step();
        start = 1'b0;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data",  32'(out_data),  32'h22);
            chk("stall_ch",    32'(out_ch),    32'd1);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        drain();

        // Snapshot isolation and start ignored while busy
        start = 1'b1; push_scan(32'h4433_2211);
        step();
        start = 1'b0;
        in_data = 32'hDDCC_BBAA;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        step(); step();
        chk("no_second_seq", 32'(out_valid), 32'd0);

        // DIRECT single beat
        in_data = 32'h4433_2211; start = 1'b1; mode = 1'b1; sel_in = 2'd2;
        sb.push_back('{d: 8'h33, ch: 2'd2, last: 1'b1});
        step();
        start = 1'b0; mode = 1'b0;
        chk("direct_ch",   32'(out_ch),   32'd2);
        chk("direct_last", 32'(out_last), 32'd1);
        step();
        chk("direct_done_busy", 32'(busy),      32'd0);
        chk("direct_done_sb",   32'(sb.size()), 32'd0);

        // DIRECT with out-of-range channel on N_CH=3
        in3_data = 24'h33_2211; start3 = 1'b1; mode3 = 1'b1; sel3 = 2'd3;
        step();
        start3 = 1'b0;
        chk("err_pulse", 32'(err3),       32'd1);
        chk("err_valid", 32'(out3_valid), 32'd0);
        chk("err_busy",  32'(busy3),      32'd0);
        step();
        chk("err_one_cycle", 32'(err3),       32'd0);
        chk("err_no_beat",   32'(out3_valid), 32'd0);

        // Reset after beat ch1
        in_data = 32'h4433_2211; start = 1'b1; mode = 1'b0;
        push_scan(32'h4433_2211);
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        chk("mrst_data",  32'(out_data),  32'd0);
        chk("mrst_ch",    32'(out_ch),    32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_last",  32'(out_last),  32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        in_data = 32'h8877_6655; start = 1'b1;
        push_scan(32'h8877_6655);
        step();
        start = 1'b0;
        chk("mrst_restart_ch", 32'(out_ch), 32'd0);
        drain();

        // Back-to-back: start held through the final handshake
        in_data = 32'h4433_2211; start = 1'b1;
        push_scan(32'h4433_2211);
        step();
        start = 1'b0;
        step(); step(); step();
        start = 1'b1; in_data = 32'h0403_0201;
        step();
        chk("b2b_gap_valid", 32'(out_valid), 32'd0);
        chk("b2b_gap_busy",  32'(busy),      32'd0);
        push_scan(32'h0403_0201);
        step();
        start = 1'b0;
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_ch",    32'(out_ch),    32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
